stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Sequencing controller for the lab-3 stopwatch datapath.
- Consumes the single-cycle tick strobes from the clock-divider FSM (1 Hz, 2 Hz, 500 Hz) and the conditioned user inputs (sel, adj, pause).
- Owns the MM:SS BCD counters and drives the 4-digit seven-segment scan (anode select plus BCD digit).
- Sits between the divider/debouncer blocks and the seven-segment decoder.

Parameters:
BLINK_EN, 1, 1 = blank the field under adjustment on alternate 2 Hz phases; 0 = never blank.
PAUSE_IN_ADJ, 0, 1 = pause pulses toggle the pause flag while in ADJ; 0 = pause pulses are ignored in ADJ.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-low reset; release is synchronous to clk.
tick_1hz  in  1  one-cycle strobe, 1 Hz count enable.
tick_2hz  in  1  one-cycle strobe, 2 Hz adjust and blink enable.
tick_scan  in  1  one-cycle strobe, 500 Hz display scan enable.
pause  in  1  debounced one-cycle pulse per press.
adj  in  1  level; 1 = adjust mode.
sel  in  1  level; 0 = adjust minutes, 1 = adjust seconds.
state  out  2  00 RUN, 01 PAUSED, 10 ADJ.
min_bcd  out  7  minutes: [6:4] tens, [3:0] ones.
sec_bcd  out  7  seconds: [6:4] tens, [3:0] ones.
an  out  4  active-low digit enable; an[3] = min tens … an[0] = sec ones.
digit  out  4  BCD value for the enabled digit.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=RUN, pause flag=0
  - min_bcd=sec_bcd=0
  - scan index=0, blink phase=0
  - an=4'b1111, digit=0
- All outputs are registered.
- State transitions, evaluated each clk edge:
  - adj=1 → ADJ from any state. adj has priority over pause.
  - In ADJ with adj=0 → PAUSED if pause flag=1, else RUN.
  - RUN with pause pulse → PAUSED, and pause flag set.
  - PAUSED with pause pulse → RUN, and pause flag cleared.
  - In ADJ, pause pulses are governed by PAUSE_IN_ADJ; state stays ADJ either way.
- RUN counting, on tick_1hz:
  - BCD increment of seconds.
  - Seconds 59→00 carries into minutes.
  - Minutes 59→00 wraps, so 59:59 → 00:00.
  - No counting in PAUSED or ADJ.
- ADJ counting, on tick_2hz:
  - sel=0: minutes increment, 59→00, seconds untouched.
  - sel=1: seconds increment, 59→00, no carry into minutes.
  - sel is sampled in the same cycle as the tick.
- Simultaneous events:
  - tick_1hz + pause pulse in RUN: the increment is applied in that cycle, and state=PAUSED next cycle.
  - tick + adj rising in the same cycle: the tick is processed per the current (pre-transition) state.
- Blink phase:
  - Toggles on every tick_2hz while in ADJ; forced to 0 outside ADJ.
  - When BLINK_EN=1 and blink phase=1, the selected field's two digits are blanked (an bit held 1). The digit value is still driven.
- Scan:
  - On tick_scan the scan index advances 0→1→2→3→0.
  - an/digit update one cycle after the tick_scan strobe (registered).
  - Index 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens; exactly one an bit is low unless blanked.
- BCD invariants: ones ≤ 9 and tens ≤ 5 at all times; no illegal BCD is reachable.
- Reset mid-operation: any state/count is cleared immediately (asynchronous), with no partial update on the release edge.

Test Plan:
- Reset: assert rst=0 mid-run at 12:34 → all outputs at reset values within the same cycle; after release, state=00 and an=1111 until the first tick_scan.
- Carry: preload to 00:59 via ADJ, RUN, one tick_1hz → min_bcd=7'h01, sec_bcd=7'h00; from 59:59 one tick → 00:00.
- Pause: in RUN, pause pulse coincident with tick_1hz at 00:10 → sec=11, state=01; further ticks leave 00:11; second pulse → state=00, next tick → 00:12.
- Adjust: adj=1, sel=0, at 58:30 apply 3 tick_2hz → 01:30 (wrap 59→00, seconds unchanged); sel=1 at 01:58, 3 ticks → 01:01 with minutes unchanged; adj=0 → RUN.
- Scan/blink: value 47:09, 4 tick_scan → (an,digit) = (1110,9), (1101,0), (1011,7), (0111,4); in ADJ sel=1 with blink phase=1 → an[1:0] stay 1.
- Priority: pause pulse during adj=1 with PAUSE_IN_ADJ=0 → exit ADJ to RUN; with PAUSE_IN_ADJ=1 → exit to PAUSED.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch sequencing: RUN/PAUSED/ADJ control, MM:SS BCD counters, 4-digit scan
module stopwatch_ctrl #(
    parameter bit BLINK_EN     = 1'b1,
    parameter bit PAUSE_IN_ADJ = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_scan,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [1:0] state,
    output logic [6:0] min_bcd,
    output logic [6:0] sec_bcd,
    output logic [3:0] an,
    output logic [3:0] digit
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSED = 2'b01,
        ST_ADJ    = 2'b10
    } state_e;

    state_e     state_q, state_d;
    logic       pflag_q, pflag_d;
    logic [6:0] min_q, min_d;
    logic [6:0] sec_q, sec_d;
    logic [1:0] scan_q, scan_d;
    logic       blink_q, blink_d;
    logic [3:0] an_q, an_d;
    logic [3:0] digit_q, digit_d;
    logic       blank;

    // Two-digit BCD increment that wraps 59 -> 00.
    function automatic logic [6:0] bcd_inc59(input logic [6:0] v);
        logic [6:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[6:4] == 3'd5) r = 7'h00;
            else                r = {v[6:4] + 3'd1, 4'd0};
        end else begin
            r = {v[6:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        pflag_d = pflag_q;
        if (adj) begin
            state_d = ST_ADJ;
        end else begin
            case (state_q)
                ST_ADJ:    state_d = pflag_q ? ST_PAUSED : ST_RUN;
                ST_RUN:    if (pause) begin
                               state_d = ST_PAUSED;
                               pflag_d = 1'b1;
                           end
                ST_PAUSED: if (pause) begin
                               state_d = ST_RUN;
                               pflag_d = 1'b0;
                           end
                default:   state_d = ST_RUN;
            endcase
        end
        if (PAUSE_IN_ADJ && state_q == ST_ADJ && pause) begin
            pflag_d = ~pflag_q;
        end
    end

    // Ticks act on the pre-transition state, so a tick coincident with adj rising still counts.
    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (state_q == ST_RUN && tick_1hz) begin
            sec_d = bcd_inc59(sec_q);
            if (sec_q == 7'h59) min_d = bcd_inc59(min_q);
        end
        if (state_q == ST_ADJ && tick_2hz) begin
            if (sel) sec_d = bcd_inc59(sec_q);
            else     min_d = bcd_inc59(min_q);
        end
        blink_d = (state_q == ST_ADJ && state_d == ST_ADJ) ? (blink_q ^ tick_2hz) : 1'b0;
    end

    always_comb begin
        scan_d  = scan_q;
        an_d    = an_q;
        digit_d = digit_q;
        blank   = BLINK_EN && blink_q && (sel ? ~scan_q[1] : scan_q[1]);
        if (tick_scan) begin
            scan_d = scan_q + 2'd1;
            an_d   = 4'b1111;
            if (!blank) an_d[scan_q] = 1'b0;
            case (scan_q)
                2'd0:    digit_d = sec_q[3:0];
                2'd1:    digit_d = {1'b0, sec_q[6:4]};
                2'd2:    digit_d = min_q[3:0];
                default: digit_d = {1'b0, min_q[6:4]};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pflag_q <= 1'b0;
            min_q   <= 7'h00;
            sec_q   <= 7'h00;
            scan_q  <= 2'd0;
            blink_q <= 1'b0;
            an_q    <= 4'b1111;
            digit_q <= 4'd0;
        end else begin
            state_q <= state_d;
            pflag_q <= pflag_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            scan_q  <= scan_d;
            blink_q <= blink_d;
            an_q    <= an_d;
            digit_q <= digit_d;
        end
    end

    assign state   = state_q;
    assign min_bcd = min_q;
    assign sec_bcd = sec_q;
    assign an      = an_q;
    assign digit   = digit_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl, both PAUSE_IN_ADJ settings
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick_1hz = 1'b0, tick_2hz = 1'b0, tick_scan = 1'b0, pause = 1'b0;
    logic adj = 1'b0, sel = 1'b0;

    logic [1:0] d_state [2];
    logic [6:0] d_min   [2];
    logic [6:0] d_sec   [2];
    logic [3:0] d_an    [2];
    logic [3:0] d_dig   [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.BLINK_EN(1'b1), .PAUSE_IN_ADJ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_scan(tick_scan),
        .pause(pause), .adj(adj), .sel(sel), .state(d_state[0]), .min_bcd(d_min[0]),
        .sec_bcd(d_sec[0]), .an(d_an[0]), .digit(d_dig[0]));

    stopwatch_ctrl #(.BLINK_EN(1'b1), .PAUSE_IN_ADJ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_scan(tick_scan),
        .pause(pause), .adj(adj), .sel(sel), .state(d_state[1]), .min_bcd(d_min[1]),
        .sec_bcd(d_sec[1]), .an(d_an[1]), .digit(d_dig[1]));

    // Reference: minutes/seconds as plain integers; state 0=RUN 1=PAUSED 2=ADJ.
    int         m_st  [2] = '{0, 0};
    int         m_flg [2] = '{0, 0};
    int         m_mm  [2] = '{0, 0};
    int         m_ss  [2] = '{0, 0};
    int         m_sc  [2] = '{0, 0};
    int         m_bl  [2] = '{0, 0};
    logic [3:0] m_an  [2] = '{4'hf, 4'hf};
    logic [3:0] m_dig [2] = '{4'h0, 4'h0};

    always @(posedge clk or negedge rst) begin : model
        int cur, nxt, idx, tot;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k] = 0; m_flg[k] = 0; m_mm[k] = 0; m_ss[k] = 0;
                m_sc[k] = 0; m_bl[k] = 0; m_an[k] = 4'hf; m_dig[k] = 4'h0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                cur = m_st[k];
                if (tick_scan) begin
                    idx = m_sc[k];
                    m_an[k] = 4'hf;
                    if (!(m_bl[k] == 1 && (sel ? idx < 2 : idx >= 2))) m_an[k][idx] = 1'b0;
                    case (idx)
                        0:       m_dig[k] = 4'(m_ss[k] % 10);
                        1:       m_dig[k] = 4'(m_ss[k] / 10);
                        2:       m_dig[k] = 4'(m_mm[k] % 10);
                        default: m_dig[k] = 4'(m_mm[k] / 10);
                    endcase
                    m_sc[k] = (idx + 1) % 4;
                end
                if (cur == 0 && tick_1hz) begin
                    tot = (m_mm[k] * 60 + m_ss[k] + 1) % 3600;
                    m_mm[k] = tot / 60;
                    m_ss[k] = tot % 60;
                end
                if (cur == 2 && tick_2hz) begin
                    if (sel) m_ss[k] = (m_ss[k] + 1) % 60;
                    else     m_mm[k] = (m_mm[k] + 1) % 60;
                end
                if (adj) nxt = 2;
                else if (cur == 2) nxt = m_flg[k];
                else if (pause) begin
                    nxt = (cur == 0) ? 1 : 0;
                    m_flg[k] = nxt;
                end else nxt = cur;
                if (cur == 2 && k == 1 && pause) m_flg[k] = 1 - m_flg[k];
                m_bl[k] = (cur == 2 && nxt == 2) ? (m_bl[k] ^ int'(tick_2hz)) : 0;
                m_st[k] = nxt;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("cyc_state%0d", k), d_state[k], m_st[k]);
            check($sformatf("cyc_min%0d", k), d_min[k], (m_mm[k] / 10) * 16 + m_mm[k] % 10);
            check($sformatf("cyc_sec%0d", k), d_sec[k], (m_ss[k] / 10) * 16 + m_ss[k] % 10);
            check($sformatf("cyc_an%0d", k), d_an[k], m_an[k]);
            check($sformatf("cyc_digit%0d", k), d_dig[k], m_dig[k]);
        end
    end

    task automatic step(input logic t1, input logic t2, input logic ts, input logic p);
        tick_1hz = t1; tick_2hz = t2; tick_scan = ts; pause = p;
        @(posedge clk);
        @(negedge clk);
        tick_1hz = 1'b0; tick_2hz = 1'b0; tick_scan = 1'b0; pause = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("rel_state", d_state[0], 0);
        check("rel_an", d_an[0], 4'hf);
        step(0, 0, 0, 0);
        check("idle_an", d_an[0], 4'hf);
        check("idle_digit", d_dig[0], 0);

        // Carry 00:59 -> 01:00
        adj = 1'b1; sel = 1'b1; step(0, 0, 0, 0);
        repeat (59) step(0, 1, 0, 0);
        adj = 1'b0; step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("carry_min", d_min[0], 7'h01);
        check("carry_sec", d_sec[0], 7'h00);

        // 59:59 -> 00:00
        adj = 1'b1; sel = 1'b0; step(0, 0, 0, 0);
        repeat (58) step(0, 1, 0, 0);
        sel = 1'b1;
        repeat (59) step(0, 1, 0, 0);
        adj = 1'b0; step(0, 0, 0, 0);
        check("pre_wrap_min", d_min[0], 7'h59);
        step(1, 0, 0, 0);
        check("wrap_min", d_min[0], 7'h00);
        check("wrap_sec", d_sec[0], 7'h00);

        // Pause coincident with tick
        repeat (10) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        check("pause_sec", d_sec[0], 7'h11);
        check("pause_state", d_state[0], 1);
        repeat (3) step(1, 0, 0, 0);
        check("paused_hold", d_sec[0], 7'h11);
        step(0, 0, 0, 1);
        check("resume_state", d_state[0], 0);
        step(1, 0, 0, 0);
        check("resume_sec", d_sec[0], 7'h12);

        // Adjust to 58:30, then minutes wrap
        adj = 1'b1; sel = 1'b0; step(0, 0, 0, 0);
        check("adj_state", d_state[0], 2);
        repeat (58) step(0, 1, 0, 0);
        sel = 1'b1;
        repeat (18) step(0, 1, 0, 0);
        sel = 1'b0;
        repeat (3) step(0, 1, 0, 0);
        check("adjm_min", d_min[0], 7'h01);
        check("adjm_sec", d_sec[0], 7'h30);
        sel = 1'b1;
        repeat (28) step(0, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        check("adjs_min", d_min[0], 7'h01);
        check("adjs_sec", d_sec[0], 7'h01);
        adj = 1'b0; step(0, 0, 0, 0);
        check("adj_exit", d_state[0], 0);

        // Scan at 47:09
        adj = 1'b1; sel = 1'b0; step(0, 0, 0, 0);
        repeat (46) step(0, 1, 0, 0);
        sel = 1'b1;
        repeat (8) step(0, 1, 0, 0);
        adj = 1'b0; step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("scan0_an", d_an[0], 4'b1110); check("scan0_dig", d_dig[0], 9);
        step(0, 0, 1, 0);
        check("scan1_an", d_an[0], 4'b1101); check("scan1_dig", d_dig[0], 0);
        step(0, 0, 1, 0);
        check("scan2_an", d_an[0], 4'b1011); check("scan2_dig", d_dig[0], 7);
        step(0, 0, 1, 0);
        check("scan3_an", d_an[0], 4'b0111); check("scan3_dig", d_dig[0], 4);

        // Blink: seconds field blanked while phase is 1
        adj = 1'b1; sel = 1'b1; step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        check("blink0_an", d_an[0], 4'b1111); check("blink0_dig", d_dig[0], 0);
        step(0, 0, 1, 0);
        check("blink1_an", d_an[0], 4'b1111);
        step(0, 0, 1, 0);
        check("blink2_an", d_an[0], 4'b1011);
        step(0, 0, 1, 0);
        check("blink3_an", d_an[0], 4'b0111);

        // Pause pulse while adjusting
        step(0, 0, 0, 1);
        check("prio_hold0", d_state[0], 2);
        check("prio_hold1", d_state[1], 2);
        adj = 1'b0; step(0, 0, 0, 0);
        check("prio_exit0", d_state[0], 0);
        check("prio_exit1", d_state[1], 1);

        // Reset mid-run at 12:34
        adj = 1'b1; sel = 1'b0; step(0, 0, 0, 0);
        repeat (25) step(0, 1, 0, 0);
        sel = 1'b1;
        repeat (24) step(0, 1, 0, 0);
        adj = 1'b0; step(0, 0, 0, 0);
        check("pre_rst_min", d_min[0], 7'h12);
        check("pre_rst_sec", d_sec[0], 7'h34);
        step(1, 0, 1, 0);
        #2 rst = 1'b0;
        #1;
        check("rst_state", d_state[0], 0);
        check("rst_min", d_min[0], 0);
        check("rst_sec", d_sec[0], 0);
        check("rst_an", d_an[0], 4'hf);
        check("rst_digit", d_dig[0], 0);
        check("rst_state1", d_state[1], 0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 0, 0);
        check("post_rst_an", d_an[0], 4'hf);
        check("post_rst_sec", d_sec[0], 7'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
